// File: rtl/tick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tick_ctrl
//  Purpose  : Timing and input-conditioning front end for the RG traffic-light
//             controller. Produces a one-cycle advance enable (tick) from the
//             board clock, synchronises and debounces the two slide switches,
//             and provides run / pause / single-step control.
//  Ports    : clk      - system clock, everything on the rising edge
//             rst      - synchronous active-high reset
//             sw[1:0]  - raw asynchronous switches (sw[0]=pause, sw[1]=step)
//             tick     - one-cycle advance enable
//             sw_db    - debounced, synchronised switch levels
//             sw_rise  - one-cycle pulse per bit on a 0->1 of sw_db
//             paused   - equals sw_db[0]
//  Revision : 1.0 - initial release
// ============================================================================
module tick_ctrl #(
  parameter int unsigned DIV       = 125_000_000,
  parameter int unsigned DB_CYCLES = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic       tick,
  output logic [1:0] sw_db,
  output logic [1:0] sw_rise,
  output logic       paused
);

  localparam int unsigned     c_PW         = $clog2(DIV);
  localparam int unsigned     c_DW         = $clog2(DB_CYCLES);
  localparam logic [c_PW-1:0] c_PCNT_MAX   = c_PW'(DIV - 1);
  localparam logic [c_DW-1:0] c_DB_MAX     = c_DW'(DB_CYCLES - 1);

  logic [1:0] w_sw_db;
  logic [1:0] w_sw_rise;

  // --------------------------------------------------------------------------
  // Per-switch two-flop synchroniser followed by a counting debouncer.
  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement clears it, so short glitches are dropped.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_bit
    logic            s1_q;
    logic            s2_q;
    logic            db_q;
    logic            db_d;
    logic            rise_q;
    logic            rise_d;
    logic [c_DW-1:0] cnt_q;
    logic [c_DW-1:0] cnt_d;

    always_comb begin
      db_d   = db_q;
      cnt_d  = cnt_q;
      rise_d = 1'b0;
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_DB_MAX) begin
        db_d   = s2_q;
        cnt_d  = '0;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= sw[gi];
        s2_q   <= s1_q;
        db_q   <= db_d;
        rise_q <= rise_d;
        cnt_q  <= cnt_d;
      end
    end

    assign w_sw_db[gi]   = db_q;
    assign w_sw_rise[gi] = rise_q;
  end

  // --------------------------------------------------------------------------
  // Prescaler. Mode decisions use the registered pause level, so the cycle in
  // which pause changes still behaves according to the previous mode. In
  // pause the phase counter is frozen and only step pulses produce ticks;
  // on resume counting continues from the frozen phase.
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] pcnt_q;
  logic [c_PW-1:0] pcnt_d;
  logic            tick_q;
  logic            tick_d;

  always_comb begin
    pcnt_d = pcnt_q;
    tick_d = 1'b0;
    if (w_sw_db[0]) begin
      tick_d = w_sw_rise[1];
    end else begin
      tick_d = (pcnt_q == c_PCNT_MAX);
      pcnt_d = (pcnt_q == c_PCNT_MAX) ? '0 : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign sw_db   = w_sw_db;
  assign sw_rise = w_sw_rise;
  assign paused  = w_sw_db[0];

endmodule
`default_nettype wire

// File: tb/tb_tick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_ctrl
//  Purpose  : Directed self-checking bench for tick_ctrl with DIV=4 and
//             DB_CYCLES=3. Cycle numbers n count rising edges after reset
//             release; inputs change 1 time unit after an edge and outputs
//             are sampled at the same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tick_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] sw;
  logic       tick;
  logic [1:0] sw_db;
  logic [1:0] sw_rise;
  logic       paused;

  int n_cmp;
  int n_err;
  int n;

  tick_ctrl #(
    .DIV       (4),
    .DB_CYCLES (3)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .tick    (tick),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .paused  (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at n=%0d: got %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 unit before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Run mode from a phase-aligned start: ticks land on multiples of 4.
  task automatic run_to(input int last);
    while (n < last) begin
      cyc();
      check("run_tick", tick, (n % 4 == 0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n     = -2;
    rst   = 1'b1;
    sw    = 2'b00;

    // Reset state
    cyc();
    cyc();
    check("rst_outs", {tick, sw_db, sw_rise, paused}, 32'h0);
    rst = 1'b0;

    // Run cadence: ticks at 4, 8, 12, 16, 20
    run_to(20);
    check("run_db", {sw_db, paused}, 32'h0);

    // Glitch of 2 cycles on sw[1] must be rejected
    sw = 2'b10;
    cyc(); check("glitch_tick", tick, 1'b0);
    cyc(); check("glitch_tick", tick, 1'b0);
    sw = 2'b00;
    while (n < 28) begin
      cyc();
      check("glitch_db_rise", {sw_db, sw_rise}, 32'h0);
      check("glitch_tick", tick, (n % 4 == 0));
    end

    // Clean sw[1] from edge 28: accepted at 33; step ignored in run mode
    sw = 2'b10;
    while (n < 36) begin
      cyc();
      check("acc_tick", tick, (n % 4 == 0));
      if (n < 33) check("acc_db_pre", sw_db, 2'b00);
      if (n == 33) check("acc_db_rise", {sw_db, sw_rise}, 4'b1010);
      if (n == 34) check("acc_rise_low", {sw_db, sw_rise}, 4'b1000);
    end
    sw = 2'b00;
    run_to(45);
    check("rel_db", sw_db, 2'b00);

    // Pause from edge 45: sw_db[0] at 50, pcnt frozen at 2
    sw = 2'b01;
    while (n < 50) begin
      cyc();
      check("pz_tick", tick, (n % 4 == 0));
      check("pz_paused", paused, (n == 50));
    end
    while (n < 70) begin
      cyc();
      check("pause_quiet", tick, 1'b0);
    end

    // Single step: rise at 75, tick at 76
    sw = 2'b11;
    while (n < 77) begin
      cyc();
      check("step1_tick", tick, (n == 76));
      if (n == 75) check("step1_rise", sw_rise, 2'b10);
    end
    sw = 2'b01;
    while (n < 82) begin
      cyc();
      check("step_rel_tick", tick, 1'b0);
    end
    check("step_rel_db", sw_db, 2'b01);
    sw = 2'b11;
    while (n < 89) begin
      cyc();
      check("step2_tick", tick, (n == 88));
      if (n == 87) check("step2_rise", sw_rise, 2'b10);
    end

    // Resume: paused falls at 94 with pcnt=2, next tick at 96, then every 4
    sw = 2'b10;
    while (n < 105) begin
      cyc();
      check("resume_tick", tick, (n == 96 || n == 100 || n == 104));
      if (n == 93) check("resume_p_hi", paused, 1'b1);
      if (n == 94) check("resume_p_lo", paused, 1'b0);
    end

    // Pause with pcnt=3, sw_db=01 (accepted at 111)
    cyc(); check("pre_rst_tick", tick, 1'b0);
    sw = 2'b01;
    while (n < 113) begin
      cyc();
      check("pre_rst_tick", tick, (n == 108));
    end
    check("pre_rst_db", sw_db, 2'b01);

    // Reset mid-operation
    rst = 1'b1;
    cyc();
    check("midrst_outs", {tick, sw_db, sw_rise, paused}, 32'h0);
    rst = 1'b0;
    n = 0;
    while (n < 8) begin
      cyc();
      check("post_rst_tick", tick, (n == 4));
      if (n == 4) check("post_rst_db4", sw_db, 2'b00);
      if (n == 5) check("post_rst_db5", {sw_db, sw_rise, paused}, 5'b01011);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
